// File: rtl/ibex_pkg.sv
// ALU operator encoding shared by the core, the coprocessor port and the ALU arbiter.
// Enumerator order follows the ibex core so operator codes line up with the real ALU.
package ibex_pkg;

  typedef enum logic [6:0] {
    ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND, ALU_XNOR, ALU_ORN, ALU_ANDN,
    ALU_SRA, ALU_SRL, ALU_SLL, ALU_SRO, ALU_SLO, ALU_ROR, ALU_ROL,
    ALU_GREV, ALU_GORC, ALU_SHFL, ALU_UNSHFL,
    ALU_XPERM_N, ALU_XPERM_B, ALU_XPERM_H,
    ALU_SH1ADD, ALU_SH2ADD, ALU_SH3ADD,
    ALU_LT, ALU_LTU, ALU_GE, ALU_GEU, ALU_EQ, ALU_NE,
    ALU_MIN, ALU_MINU, ALU_MAX, ALU_MAXU,
    ALU_PACK, ALU_PACKU, ALU_PACKH, ALU_SEXTB, ALU_SEXTH,
    ALU_CLZ, ALU_CTZ, ALU_CPOP, ALU_SLT, ALU_SLTU,
    ALU_CMOV, ALU_CMIX, ALU_FSL, ALU_FSR,
    ALU_BSET, ALU_BCLR, ALU_BINV, ALU_BEXT, ALU_BCOMPRESS, ALU_BDECOMPRESS, ALU_BFP,
    ALU_CLMUL, ALU_CLMULR, ALU_CLMULH,
    ALU_CRC32_B, ALU_CRC32C_B, ALU_CRC32_H, ALU_CRC32C_H, ALU_CRC32_W, ALU_CRC32C_W
  } alu_op_e;

endpackage

// File: rtl/ibex_alu_arbiter.sv
// Round-robin sharing of one combinational ibex ALU between the ID/EX stage (port 0)
// and the custom-instruction coprocessor port (port 1); one operation in flight at a time.
module ibex_alu_arbiter #(
  parameter bit BackToBack = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [1:0]         req_valid_i,
  output logic [1:0]         req_ready_o,
  input  ibex_pkg::alu_op_e  req_operator_i [2],
  input  logic [31:0]        req_operand_a_i [2],
  input  logic [31:0]        req_operand_b_i [2],
  output logic [1:0]         rsp_valid_o,
  input  logic [1:0]         rsp_ready_i,
  output logic [31:0]        rsp_result_o,
  output logic               rsp_cmp_o,
  output ibex_pkg::alu_op_e  alu_operator_o,
  output logic [31:0]        alu_operand_a_o,
  output logic [31:0]        alu_operand_b_o,
  output logic               alu_multdiv_en_o,
  input  logic [31:0]        alu_result_i,
  input  logic               alu_comparison_result_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e            state_q;
  state_e            state_d;
  logic              last_q;
  logic              gnt_q;
  ibex_pkg::alu_op_e op_q;
  logic [31:0]       a_q;
  logic [31:0]       b_q;
  logic [31:0]       res_q;
  logic              cmp_q;

  logic              any_req;
  logic              gnt;
  logic              accept;

  // Round-robin pick: a lone request always wins, a tie goes to the requester not served last.
  always_comb begin
    any_req = |req_valid_i;
    if (req_valid_i == 2'b11) begin
      gnt = ~last_q;
    end else begin
      gnt = req_valid_i[1];
    end
  end

  // Next-state logic; accept marks the cycle in which a request handshake completes.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          accept  = 1'b1;
          state_d = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        state_d = RESP;
      end
      RESP: begin
        // Only the granted requester's ready completes the response.
        if (rsp_ready_i[gnt_q]) begin
          if (BackToBack && any_req) begin
            accept  = 1'b1;
            state_d = EXEC;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request ready is combinational so the accept lands in the same cycle as the grant.
  always_comb begin
    req_ready_o = 2'b00;
    if (accept && rst_ni) begin
      req_ready_o[gnt] = 1'b1;
    end else begin
      req_ready_o = 2'b00;
    end
  end

  // Response valid decoded from the state register and the stored grant.
  always_comb begin
    rsp_valid_o = 2'b00;
    if (state_q == RESP) begin
      rsp_valid_o[gnt_q] = 1'b1;
    end else begin
      rsp_valid_o = 2'b00;
    end
  end

  // The ALU sees the captured operation only while evaluating; otherwise it is parked at ADD 0,0.
  always_comb begin
    alu_operator_o  = ibex_pkg::ALU_ADD;
    alu_operand_a_o = 32'd0;
    alu_operand_b_o = 32'd0;
    if (state_q == EXEC) begin
      alu_operator_o  = op_q;
      alu_operand_a_o = a_q;
      alu_operand_b_o = b_q;
    end else begin
      alu_operator_o  = ibex_pkg::ALU_ADD;
      alu_operand_a_o = 32'd0;
      alu_operand_b_o = 32'd0;
    end
  end

  assign rsp_result_o     = res_q;
  assign rsp_cmp_o        = cmp_q;
  assign alu_multdiv_en_o = 1'b0;

  // State, arbitration history and operation capture.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      op_q    <= ibex_pkg::ALU_ADD;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q   <= req_operator_i[gnt];
        a_q    <= req_operand_a_i[gnt];
        b_q    <= req_operand_b_i[gnt];
        gnt_q  <= gnt;
        last_q <= gnt;
      end
    end
  end

  // Result capture at the end of the evaluation cycle; held until the next evaluation.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      res_q <= 32'd0;
      cmp_q <= 1'b0;
    end else if (state_q == EXEC) begin
      res_q <= alu_result_i;
      cmp_q <= alu_comparison_result_i;
    end
  end

endmodule
